// File: rtl/vga_capture.sv
// vga_capture
//   Receive end of the VGA link. Samples h_sync/v_sync/RGB332 once per pixel
//   clock. After one fully verified frame it locks to the sync timing and
//   writes every visible pixel to frame memory as {y, x} address plus 8-bit data.
//
// Ports
//   clk        in   pixel clock, the same clock as the source
//   rst_n      in   asynchronous reset, active-low
//   h_sync     in   horizontal sync, active-low pulse
//   v_sync     in   vertical sync, active-low pulse
//   red        in   3-bit pixel red
//   green      in   3-bit pixel green
//   blue       in   2-bit pixel blue
//   wr_en      out  write strobe, one clk per visible pixel
//   wr_addr    out  {y[9:0], x[9:0]}, holds its value between writes
//   wr_data    out  {red, green, blue}, holds its value between writes
//   locked     out  level, high while the FSM is in LOCKED
//   frame_done out  1-clk pulse alongside the write of the last visible pixel
//   timing_err out  1-clk pulse on a line/frame length mismatch or sync timeout
//   state_dbg  out  current FSM state: 0 SEARCH, 1 MEASURE, 2 LOCKED
module vga_capture #(
    parameter int H_WHOLE_LINE  = 1024,
    parameter int V_WHOLE_FRAME = 625,
    parameter int H_START       = 97,
    parameter int H_VISIBLE     = 800,
    parameter int V_START       = 3,
    parameter int V_VISIBLE     = 600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [1:0]  blue,
    output logic        wr_en,
    output logic [19:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        locked,
    output logic        frame_done,
    output logic        timing_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [10:0] H_LAST  = 11'(H_WHOLE_LINE - 1);
    localparam logic [10:0] H_TO    = 11'(H_WHOLE_LINE);
    localparam logic [9:0]  V_LAST  = 10'(V_WHOLE_FRAME - 1);
    localparam logic [10:0] H_LO    = 11'(H_START);
    localparam logic [10:0] H_HI    = 11'(H_START + H_VISIBLE);
    localparam logic [9:0]  V_LO    = 10'(V_START);
    localparam logic [9:0]  V_HI    = 10'(V_START + V_VISIBLE);
    localparam logic [9:0]  H_LO10  = 10'(H_START);
    localparam logic [10:0] H_SAT   = 11'h7FF;
    localparam logic [9:0]  V_SAT   = 10'h3FF;

    state_t      state, state_nx;
    logic        prev_h, prev_v;
    logic [10:0] hcnt;
    logic [9:0]  vcnt;
    logic        frame_bad;

    logic        h_fall, v_fall;
    logic        line_bad, timeout, line_err, frame_ok;
    logic        err;
    logic        visible;
    logic [9:0]  x_pix, y_pix;

    assign h_fall   = prev_h & ~h_sync;
    assign v_fall   = prev_v & ~v_sync;

    // A line is judged when it ends (h_fall); a line that never ends is
    // caught once the counter passes the nominal length.
    assign line_bad = h_fall && (hcnt != H_LAST);
    assign timeout  = !h_fall && (hcnt == H_TO);
    assign line_err = line_bad | timeout;

    // v_fall must coincide with h_fall; the line ending here is the last
    // line of the frame and is part of the frame verdict.
    assign frame_ok = v_fall && h_fall && !line_bad && !frame_bad && (vcnt == V_LAST);

    assign locked    = (state == LOCKED);
    assign state_dbg = state;

    always_comb begin
        state_nx = state;
        err      = 1'b0;
        case (state)
            SEARCH: begin
                if (v_fall) state_nx = MEASURE;
            end
            MEASURE: begin
                if (v_fall) begin
                    if (frame_ok) begin
                        state_nx = LOCKED;
                    end else begin
                        state_nx = MEASURE;
                        err      = 1'b1;
                    end
                end else if (timeout) begin
                    state_nx = SEARCH;
                    err      = 1'b1;
                end
            end
            LOCKED: begin
                if ((v_fall && !frame_ok) || line_err) begin
                    state_nx = SEARCH;
                    err      = 1'b1;
                end
            end
            default: state_nx = SEARCH;
        endcase
    end

    // The error cycle itself never writes, so a lock loss mid-line stops
    // the strobe immediately.
    assign visible = (state == LOCKED) && !err &&
                     (hcnt >= H_LO) && (hcnt < H_HI) &&
                     (vcnt >= V_LO) && (vcnt < V_HI);

    assign x_pix = hcnt[9:0] - H_LO10;
    assign y_pix = vcnt - V_LO;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            prev_h     <= 1'b1;
            prev_v     <= 1'b1;
            hcnt       <= '0;
            vcnt       <= '0;
            frame_bad  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            state  <= state_nx;
            prev_h <= h_sync;
            prev_v <= v_sync;

            if (h_fall)             hcnt <= '0;
            else if (hcnt != H_SAT) hcnt <= hcnt + 11'd1;

            // v_fall wins: both syncs fall together at frame start.
            if (v_fall)                       vcnt <= '0;
            else if (h_fall && vcnt != V_SAT) vcnt <= vcnt + 10'd1;

            if (v_fall)        frame_bad <= 1'b0;
            else if (line_err) frame_bad <= 1'b1;

            wr_en      <= visible;
            frame_done <= visible && (hcnt == H_HI - 11'd1) && (vcnt == V_HI - 10'd1);
            timing_err <= err;
            if (visible) begin
                wr_addr <= {y_pix, x_pix};
                wr_data <= {red, green, blue};
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture
//   Drives scaled-down VGA timing (64-clk lines, 30-line frames) with random
//   pixel data and checks every cycle against a line-level reference model.
module tb_vga_capture;
  localparam int H     = 64;
  localparam int V     = 30;
  localparam int HS    = 8;
  localparam int VS    = 2;
  localparam int H_ST  = 13;
  localparam int HV    = 40;
  localparam int V_ST  = 3;
  localparam int VV    = 24;

  logic        clk;
  logic        rst_n;
  logic        h_sync, v_sync;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic        wr_en;
  logic [19:0] wr_addr;
  logic [7:0]  wr_data;
  logic        locked, frame_done, timing_err;
  logic [1:0]  state_dbg;

  vga_capture #(
    .H_WHOLE_LINE (H),
    .V_WHOLE_FRAME(V),
    .H_START      (H_ST),
    .H_VISIBLE    (HV),
    .V_START      (V_ST),
    .V_VISIBLE    (VV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .locked    (locked),
    .frame_done(frame_done),
    .timing_err(timing_err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: {frame_done, y, x, data}
  logic [28:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_writes, n_done, n_terr;
  logic [19:0] first_addr, last_addr;
  bit          first_seen;
  logic [19:0] hold_addr;
  logic [7:0]  hold_data;

  // reference model (line granularity): 0 SEARCH, 1 MEASURE, 2 LOCKED
  int m_state, m_line, m_len;
  bit m_fbad;

  task automatic model_reset();
    m_state   = 0;
    m_line    = 0;
    m_len     = 0;
    m_fbad    = 0;
    hold_addr = '0;
    hold_data = '0;
    exp_q.delete();
  endtask

  // One line of len samples; h_sync low for the first HS samples.
  // Only samples [from, upto) are driven, so a line can be split.
  task automatic send_line(input int len, input bit vlow, input bit vfall,
                           input int from, input int upto);
    for (int s = from; s < upto; s++) begin
      bit          vis, terr, lok, fok;
      int          x, y;
      logic [7:0]  d;
      logic [28:0] e;
      @(negedge clk);
      terr   = 0;
      h_sync = (s < HS) ? 1'b0 : 1'b1;
      v_sync = vlow ? 1'b0 : 1'b1;
      d      = 8'($urandom);
      {red, green, blue} = d;
      if (s == 0) begin
        lok = (m_len == H);
        if (vfall) begin
          fok = lok && !m_fbad && (m_line + 1 == V);
          if (m_state == 0) m_state = 1;
          else if (m_state == 1) begin
            if (fok) m_state = 2; else terr = 1;
          end else if (!fok) begin
            m_state = 0;
            terr = 1;
          end
          m_line = 0;
          m_fbad = 0;
        end else begin
          if (!lok) begin
            m_fbad = 1;
            if (m_state == 2) begin m_state = 0; terr = 1; end
          end
          m_line++;
        end
        m_len = 0;
      end
      if (s == H + 1 && m_state != 0) begin
        m_state = 0;
        terr = 1;
      end
      m_len++;
      x   = s - 1 - H_ST;
      y   = m_line - V_ST;
      vis = (s >= 1) && (m_state == 2) && (x >= 0) && (x < HV) && (y >= 0) && (y < VV);
      if (vis) begin
        e = {((x == HV - 1) && (y == VV - 1)), 10'(y), 10'(x), d};
        exp_q.push_back(e);
        hold_addr = {10'(y), 10'(x)};
        hold_data = d;
      end
      @(posedge clk);
      #1;
      total++;
      if (timing_err !== terr) begin
        bad++;
        $display("FAIL timing_err line=%0d s=%0d got=%b exp=%b", m_line, s, timing_err, terr);
      end
      total++;
      if (locked !== (m_state == 2)) begin
        bad++;
        $display("FAIL locked line=%0d s=%0d got=%b exp=%b", m_line, s, locked, (m_state == 2));
      end
      total++;
      if (wr_en !== vis) begin
        bad++;
        $display("FAIL wr_en line=%0d s=%0d got=%b exp=%b", m_line, s, wr_en, vis);
        if (vis) exp_q.delete(0);
      end else if (wr_en === 1'b1) begin
        n_writes++;
        if (frame_done === 1'b1) n_done++;
        if (!first_seen) begin first_addr = wr_addr; first_seen = 1; end
        last_addr = wr_addr;
        e = exp_q.pop_front();
        total++;
        if ({frame_done, wr_addr, wr_data} !== e) begin
          bad++;
          $display("FAIL write line=%0d s=%0d got=%h exp=%h", m_line, s,
                   {frame_done, wr_addr, wr_data}, e);
        end
      end else begin
        total++;
        if (frame_done !== 1'b0 || wr_addr !== hold_addr || wr_data !== hold_data) begin
          bad++;
          $display("FAIL idle_hold line=%0d s=%0d got=%b/%h/%h exp=0/%h/%h", m_line, s,
                   frame_done, wr_addr, wr_data, hold_addr, hold_data);
        end
      end
      if (timing_err === 1'b1) n_terr++;
    end
  endtask

  task automatic send_frame_lines(input int first, input int last,
                                  input int bad_line, input int bad_len);
    for (int l = first; l <= last; l++) begin
      int len;
      len = (l == bad_line) ? bad_len : H;
      send_line(len, (l < VS), (l == 0), 0, len);
    end
  endtask

  task automatic clear_counts();
    n_writes   = 0;
    n_done     = 0;
    n_terr     = 0;
    first_seen = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    h_sync = 1'b1; v_sync = 1'b1;
    {red, green, blue} = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({wr_en, locked, frame_done, timing_err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000", {wr_en, locked, frame_done, timing_err});
    end
    total++;
    if (wr_addr !== 20'h0 || wr_data !== 8'h00 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL reset_values got=%h/%h/%0d exp=0/0/0", wr_addr, wr_data, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock();
    clear_counts();
    send_line(H, 1'b1, 1'b1, 0, 1);
    total++;
    if (locked !== 1'b0 || state_dbg !== 2'd1) begin
      bad++;
      $display("FAIL lock_measure got=%b/%0d exp=0/1", locked, state_dbg);
    end
    send_line(H, 1'b1, 1'b1, 1, H);
    send_frame_lines(1, V - 1, -1, 0);
    send_line(H, 1'b1, 1'b1, 0, 1);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL lock_rise got=%b exp=1", locked);
    end
    total++;
    if (n_writes !== 0) begin
      bad++;
      $display("FAIL lock_no_writes got=%0d exp=0", n_writes);
    end
    send_line(H, 1'b1, 1'b1, 1, H);
  endtask

  task automatic test_capture();
    clear_counts();
    send_frame_lines(1, V - 1, -1, 0);
    total++;
    if (n_writes !== HV * VV) begin
      bad++;
      $display("FAIL capture_count got=%0d exp=%0d", n_writes, HV * VV);
    end
    total++;
    if (first_addr !== 20'h00000) begin
      bad++;
      $display("FAIL capture_first got=%h exp=00000", first_addr);
    end
    total++;
    if (last_addr !== {10'(VV - 1), 10'(HV - 1)} || n_done !== 1) begin
      bad++;
      $display("FAIL capture_last got=%h done=%0d exp=%h done=1", last_addr, n_done,
               {10'(VV - 1), 10'(HV - 1)});
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL capture_queue got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_short_line();
    clear_counts();
    send_frame_lines(0, V - 1, 5, H - 1);
    total++;
    if (n_terr !== 1 || locked !== 1'b0) begin
      bad++;
      $display("FAIL short_err got=%0d/%b exp=1/0", n_terr, locked);
    end
    total++;
    if (n_writes !== (6 - V_ST) * HV) begin
      bad++;
      $display("FAIL short_writes got=%0d exp=%0d", n_writes, (6 - V_ST) * HV);
    end
    send_frame_lines(0, V - 1, -1, 0);
    send_line(H, 1'b1, 1'b1, 0, 1);
    total++;
    if (locked !== 1'b1 || n_terr !== 1) begin
      bad++;
      $display("FAIL short_relock got=%b/%0d exp=1/1", locked, n_terr);
    end
    send_line(H, 1'b1, 1'b1, 1, H);
    send_frame_lines(1, V - 1, -1, 0);
  endtask

  task automatic test_timeout();
    clear_counts();
    send_frame_lines(0, 7, -1, 0);
    send_line(3 * H, 1'b0, 1'b0, 0, 3 * H);
    total++;
    if (n_terr !== 1 || locked !== 1'b0 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL timeout got=%0d/%b/%0d exp=1/0/0", n_terr, locked, state_dbg);
    end
  endtask

  task automatic test_bad_frame();
    clear_counts();
    send_frame_lines(0, V - 2, -1, 0);
    total++;
    if (n_terr !== 0 || state_dbg !== 2'd1) begin
      bad++;
      $display("FAIL badframe_enter got=%0d/%0d exp=0/1", n_terr, state_dbg);
    end
    send_line(H, 1'b1, 1'b1, 0, 1);
    total++;
    if (n_terr !== 1 || locked !== 1'b0 || state_dbg !== 2'd1) begin
      bad++;
      $display("FAIL badframe_err got=%0d/%b/%0d exp=1/0/1", n_terr, locked, state_dbg);
    end
    send_line(H, 1'b1, 1'b1, 1, H);
    send_frame_lines(1, V - 1, -1, 0);
    send_line(H, 1'b1, 1'b1, 0, 1);
    total++;
    if (locked !== 1'b1) begin
      bad++;
      $display("FAIL badframe_relock got=%b exp=1", locked);
    end
    send_line(H, 1'b1, 1'b1, 1, H);
  endtask

  task automatic test_reset_mid();
    clear_counts();
    send_frame_lines(1, 9, -1, 0);
    send_line(H, 1'b0, 1'b0, 0, H_ST + 6);
    total++;
    if (wr_en !== 1'b1 || locked !== 1'b1) begin
      bad++;
      $display("FAIL midreset_pre got=%b/%b exp=1/1", wr_en, locked);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({wr_en, locked, frame_done, timing_err} !== 4'b0000 || state_dbg !== 2'd0) begin
      bad++;
      $display("FAIL midreset_async got=%b/%0d exp=0000/0",
               {wr_en, locked, frame_done, timing_err}, state_dbg);
    end
    model_reset();
    @(negedge clk);
    h_sync = 1'b1; v_sync = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    send_frame_lines(11, V - 1, -1, 0);
    send_line(H, 1'b1, 1'b1, 0, 1);
    total++;
    if (locked !== 1'b0 || state_dbg !== 2'd1) begin
      bad++;
      $display("FAIL midreset_measure got=%b/%0d exp=0/1", locked, state_dbg);
    end
    send_line(H, 1'b1, 1'b1, 1, H);
    send_frame_lines(1, V - 1, -1, 0);
    send_line(H, 1'b1, 1'b1, 0, 1);
    total++;
    if (locked !== 1'b1 || n_writes !== 0) begin
      bad++;
      $display("FAIL midreset_relock got=%b/%0d exp=1/0", locked, n_writes);
    end
    send_line(H, 1'b1, 1'b1, 1, H);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_capture();
    test_short_line();
    test_timeout();
    test_bad_frame();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
